// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, controller states and the request legality check
// shared by the load/store controller and its lane logic.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RD, WR, EXT} lsu_state_t;

    // Unsigned sizes are load-only, so a store with funct3[2] set is illegal.
    function automatic logic lsu_bad(input logic we, input logic [2:0] funct3, input logic [1:0] off);
        logic illegal;
        logic misaligned;
        illegal    = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (we && funct3[2]);
        misaligned = (funct3[1:0] == 2'b01 && off[0]) || (funct3 == F3_W && off != 2'b00);
        return illegal || misaligned;
    endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: little-endian lane select with sign/zero extension for loads, and
// byte/half merge into the previously read word for stores.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [4:0]  hsh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    logic [31:0] ins;

    always_comb begin
        sh     = {off, 3'b000};
        hsh    = {off[1], 4'b0000};
        b      = 8'(mem_rd >> sh);
        h      = off[1] ? mem_rd[31:16] : mem_rd[15:0];
        rdata  = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_BU ? {24'h0, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_HU ? {16'h0, h} : mem_rd;
        mask   = funct3[1:0] == 2'b00 ? 32'h0000_00FF << sh : 32'h0000_FFFF << hsh;
        ins    = funct3[1:0] == 2'b00 ? {24'h0, wdata[7:0]} << sh : {16'h0, wdata[15:0]} << hsh;
        merged = funct3 == F3_W ? wdata : (mem_rd & ~mask) | (ins & mask);
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store initiator for a word-addressed, 1-cycle-latency
// single-port memory; sub-word stores are done by read-modify-write.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    lsu_state_t              state;
    lsu_state_t              state_n;
    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             ld_data;
    logic [31:0]             st_data;
    logic                    accept;
    logic                    bad;
    logic                    unused_addr;

    // Upper address bits are dropped so accesses wrap over the memory.
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
    assign req_ready   = state == IDLE;
    assign accept      = req_valid && req_ready;
    assign bad         = lsu_bad(req_we, req_funct3, req_addr[1:0]);

    lsu_lane u_lane (
        .mem_rd (mem_rd),
        .wdata  (wdata_q),
        .off    (addr_q[1:0]),
        .funct3 (funct3_q),
        .rdata  (ld_data),
        .merged (st_data)
    );

    always_comb begin
        state_n = state;
        mem_a   = addr_q[ADDR_WIDTH+1:2];
        mem_we  = 1'b0;
        mem_wd  = '0;
        case (state)
            IDLE: if (accept && !bad) state_n = (req_we && req_funct3 == F3_W) ? WR : RD;
            RD:   state_n = we_q ? WR : EXT;
            WR: begin
                state_n = IDLE;
                mem_we  = !rst;
                mem_wd  = st_data;
            end
            EXT:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            resp_valid <= (accept && bad) || state == WR || state == EXT;
            resp_err   <= accept && bad;
            resp_rdata <= state == EXT ? ld_data : '0;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[ADDR_WIDTH+1:0];
                wdata_q  <= req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl against a byte-array model
// of memory, with the controller attached to a 1-cycle-latency word memory.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [1024];
    logic [7:0]  ref_b [4096];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;

    typedef struct {logic err; logic [31:0] rdata; int t0; int lat;} exp_t;
    typedef struct {int cyc; logic [9:0] a; logic [31:0] wd;} wr_t;
    exp_t sbq[$];
    wr_t  wq[$];

    lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
        mem_rd <= mem[mem_a];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return a[0];
            3'd2:    return a[1:0] != 2'd0;
            3'd4:    return we;
            3'd5:    return we || a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [9:0] w);
        return {ref_b[{w, 2'd3}], ref_b[{w, 2'd2}], ref_b[{w, 2'd1}], ref_b[{w, 2'd0}]};
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        wr_t  w;
        if (resp_valid) begin
            if (sbq.size() == 0) chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            else begin
                e = sbq.pop_front();
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_latency", cyc - e.t0, e.lat);
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end
        end
        if (mem_we) begin
            if (wq.size() == 0) chk("unexpected_write", {31'd0, mem_we}, 32'd0);
            else begin
                w = wq.pop_front();
                chk("write_cycle", cyc, w.cyc);
                chk("write_addr", {22'd0, mem_a}, {22'd0, w.a});
                chk("write_data", mem_wd, w.wd);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int t0);
        exp_t        e;
        wr_t         w;
        int          n;
        int          k;
        logic [11:0] bi;
        logic [31:0] v;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        t0 = cyc;
        if (!req_ready) begin
            chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        n       = nbytes(f3);
        bi      = a[11:0];
        e.t0    = cyc;
        e.err   = ref_err(we, f3, a);
        e.rdata = 32'd0;
        e.lat   = e.err ? 1 : (we && f3 == 3'd2) ? 2 : 3;
        if (!e.err && !we) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v |= 32'(ref_b[bi + 12'(i)]) << (8 * i);
            if (f3 == 3'd0 && v[7])  v |= 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v |= 32'hFFFF_0000;
            e.rdata = v;
        end
        if (!e.err && we) begin
            for (int i = 0; i < n; i++) ref_b[bi + 12'(i)] = wd[8 * i +: 8];
            w.cyc = cyc + (f3 == 3'd2 ? 1 : 2);
            w.a   = a[11:2];
            w.wd  = ref_word(a[11:2]);
            wq.push_back(w);
        end
        sbq.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sbq.size() != 0 || wq.size() != 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(sbq.size() + wq.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int          t;
        int          t_a;
        int          t_b;
        int          bad;
        logic [31:0] v;
        logic [31:0] a;
        logic [2:0]  f3;
        logic        we;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i] <= v;
            for (int j = 0; j < 4; j++) ref_b[4 * i + j] = v[8 * j +: 8];
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_a", {22'd0, mem_a}, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);

        issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, t);
        issue(1'b0, 3'd2, 32'h10, 32'd0, t);
        wait_idle();
        chk("lw_deadbeef", last_rdata, 32'hDEAD_BEEF);

        issue(1'b1, 3'd0, 32'h13, 32'h80, t);
        wait_idle();
        chk("sb_word", mem[4], 32'h80AD_BEEF);
        issue(1'b0, 3'd0, 32'h13, 32'd0, t);
        wait_idle();
        chk("lb_signed", last_rdata, 32'hFFFF_FF80);
        issue(1'b0, 3'd4, 32'h13, 32'd0, t);
        wait_idle();
        chk("lbu_zero", last_rdata, 32'h0000_0080);

        issue(1'b1, 3'd1, 32'h12, 32'h1234, t);
        wait_idle();
        chk("sh_word", mem[4], 32'h1234_BEEF);
        issue(1'b0, 3'd1, 32'h12, 32'd0, t);
        wait_idle();
        chk("lh_hi", last_rdata, 32'h0000_1234);
        issue(1'b0, 3'd5, 32'h10, 32'd0, t);
        wait_idle();
        chk("lhu_lo", last_rdata, 32'h0000_BEEF);

        issue(1'b0, 3'd2, 32'h11, 32'd0, t);
        issue(1'b0, 3'd1, 32'h13, 32'd0, t);
        issue(1'b0, 3'd3, 32'h10, 32'd0, t);
        issue(1'b1, 3'd4, 32'h10, 32'hFF, t);
        issue(1'b1, 3'd2, 32'h12, 32'hFFFF_FFFF, t);
        wait_idle();
        chk("err_flag", {31'd0, last_err}, 32'd1);
        chk("err_word_kept", mem[4], 32'h1234_BEEF);

        // Reset lands in the write cycle of a byte store.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h10;
        req_wdata  = 32'hFF;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("abort_word_kept", mem[4], 32'h1234_BEEF);

        issue(1'b1, 3'd2, 32'h20, 32'hA5A5_5A5A, t_a);
        issue(1'b0, 3'd2, 32'h20, 32'd0, t_b);
        chk("b2b_accept_gap", t_b - t_a, 32'd2);
        wait_idle();
        chk("b2b_data", last_rdata, 32'hA5A5_5A5A);

        for (int i = 0; i < 400; i++) begin
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(f3) - 1);
            issue(we, f3, a, $urandom, t);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_word(10'(i))) bad++;
        chk("mem_image", bad, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller: the initiator side of the CPU data-memory port. Accepts one RV32I load/store per handshake from the execute/memory stage using a byte address and funct3. Drives the word-addressed, single-port, 1-cycle-read-latency data memory (no byte enables). Performs byte/half-word stores by read-modify-write and returns sign- or zero-extended load data.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width; only 32 is supported.
- ADDR_WIDTH, 10, memory word-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_a  out  ADDR_WIDTH  word address, equal to addr[ADDR_WIDTH+1:2].
- mem_we  out  1  memory write enable.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  memory read data; valid the cycle after the address is presented with mem_we=0.

## Operation
- States: IDLE, RD, WR, EXT.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid && req_ready) captures we, funct3, addr and wdata.
- Error check at accept:
  - funct3 011, 110 or 111 is an error, as is a store using 100 or 101.
  - H/HU with addr[0]≠0 is an error; W with addr[1:0]≠0 is an error.
  - Error path: stay in IDLE, register resp_valid=1 and resp_err=1. No memory access is made.
- Routing at accept:
  - Load → RD → EXT → IDLE.
  - SW → WR → IDLE.
  - SB/SH → RD → WR → IDLE.
- RD:
  - mem_a = captured word address, mem_we=0.
  - For SB/SH, the next state is WR and uses mem_rd as the merge base.
- EXT:
  - Select the byte lane addr[1:0] or half lane addr[1]. Byte order is little-endian.
  - B/H sign-extend; BU/HU zero-extend; W is passed through.
  - Register resp_rdata and resp_valid.
- WR:
  - mem_we=1.
  - SW: mem_wd = wdata.
  - SB: mem_rd with the selected byte replaced by wdata[7:0].
  - SH: mem_rd with the selected half replaced by wdata[15:0].
  - Register resp_valid=1 and resp_err=0.
- Output registration:
  - mem_a, mem_we and mem_wd decode from state and captured registers only, never directly from req_* inputs.
  - resp_* are registered.
- Address range: req_addr bits above ADDR_WIDTH+1 are ignored, so accesses wrap modulo the memory size. No error is raised.

## Timing
- T0 is the accept cycle. Latency to resp_valid:
  - Error: T1.
  - SW: write in T1, resp_valid in T2.
  - Load: RD in T1, EXT in T2, resp_valid in T3.
  - SB/SH: RD in T1, WR in T2, resp_valid in T3.
- resp_valid is high for exactly one cycle. req_ready is high in that same cycle, so a new request may be accepted in the response cycle.
- Requests arriving while req_ready=0 are not captured. The requester must hold its request until the handshake.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_a=0, mem_wd=0, all captured registers 0.
- mem_we is gated with !rst. Reset asserted during WR therefore performs no write.
- Reset mid-operation aborts the access, produces no resp_valid pulse, and the controller is in IDLE the cycle after reset deasserts.

## Structure
- Package lsu_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - state enum lsu_state_t {IDLE, RD, WR, EXT};
  - the misalignment and illegal-funct3 check function.
- Sub-module lsu_lane: purely combinational. Provides load extract/extend (mem_rd, addr[1:0], funct3 → rdata) and store merge (mem_rd, wdata, addr[1:0], funct3 → merged word). Instantiated once in lsu_mem_ctrl.
- Test bench connects lsu_mem_ctrl to the existing data memory.

## Test plan
- After reset: req_ready=1, resp_valid=0, mem_we=0. Then SW 0xDEADBEEF @0x10: mem_we=1 only in T1, resp_valid in T2. LW @0x10 then returns 0xDEADBEEF with resp_valid in T3.
- With word @0x10 = 0xDEADBEEF: SB 0x80 @0x13 → memory word 0x80ADBEEF. Then LB @0x13 → 0xFFFFFF80 and LBU @0x13 → 0x00000080.
- SH 0x1234 @0x12 on the same word → 0x1234BEEF. Then LH @0x12 → 0x00001234 and LHU @0x10 → 0x0000BEEF.
- Error cases: LW @0x11, LH @0x13 and funct3=011 each give resp_valid=1, resp_err=1 in T1. mem_we never asserts and the memory contents are unchanged.
- Assert rst in T2 of SB 0xFF @0x10: no write (word unchanged), no resp_valid, req_ready=1 after reset deasserts.
- Back-to-back: accept LW in the response cycle of a preceding SW. Read data reflects the new store. The two responses are exactly 3 cycles apart.
